// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the seven-segment scan driver.
//   digit_t    : one BCD digit code (0-9 valid, 10-15 render blank)
//   seg_t      : active-low segment pattern, bit order gfedcba
//   SEG_BLANK  : all segments off
//   SEG_TABLE  : active-low patterns for digits 0-9
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Index 0 is the pattern for digit 0; common-anode, so 0 lights a segment.
    localparam seg_t SEG_TABLE [10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD to active-low seven-segment decoder.
// Ports:
//   digit : input  digit_t  digit code to render
//   seg   : output seg_t    gfedcba pattern, 0 = lit; codes 10-15 give blank
// -----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  digit_t digit,
    output seg_t   seg
);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        seg = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (digit == 4'(i)) begin
                seg = SEG_TABLE[i];
            end
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed multi-digit seven-segment driver for common-anode displays.
// A prescaler divides each digit slot into SCAN_DIV cycles; the first
// BLANK_CYC cycles of every slot keep all digits dark to avoid ghosting.
// New values are captured into a pending buffer and only transferred to the
// display buffer at the frame boundary, so a frame never shows mixed values.
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   defined   : zero digits above the most significant non-zero digit are
//               blanked; digit 0 is always shown.
//   undefined : every digit is decoded as-is.
//
// Parameters:
//   NUM_DIGITS : digits scanned (1-8)
//   SCAN_DIV   : clock cycles per digit slot (>= 2)
//   BLANK_CYC  : dark cycles at the start of each slot (< SCAN_DIV)
// Ports:
//   clk         : input   system clock, rising edge
//   rst_n       : input   asynchronous active-low reset
//   load        : input   one-cycle strobe, capture bcd_in
//   bcd_in      : input   packed digits, digit 0 = bits [3:0] = rightmost
//   seg         : output  segment bus gfedcba, active-low
//   an          : output  digit enables, active-low one-hot, all ones when dark
//   frame_start : output  pulse coincident with the digit-0 blank cycle 0
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Reject illegal configurations at elaboration time.
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("seg7_scan_driver: NUM_DIGITS must be 1..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("seg7_scan_driver: SCAN_DIV must be >= 2");
    end
    if (BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_bad_blank_cyc
        $error("seg7_scan_driver: BLANK_CYC must be in 0..SCAN_DIV-1");
    end

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [PRE_W-1:0]        pre_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    frame_wrap;
    logic                    in_blank;

    // Last cycle of the last slot: the next edge enters digit 0, cycle 0.
    assign frame_wrap = (pre_q == PRE_LAST) && (idx_q == IDX_LAST);
    assign in_blank   = (pre_q < PRE_W'(BLANK_CYC));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            // With a single digit IDX_LAST is 0, so the index stays at 0.
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Double buffer: pending captures loads, display changes only on wrap
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] pending_q;
    logic                    pending_valid_q;
    logic [4*NUM_DIGITS-1:0] display_q;

    // NOTE: the data buffers are reset too, not just the control bits, so
    // the display reliably shows zeros out of reset instead of random digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            display_q       <= '0;
        end else if (frame_wrap) begin
            // A load on the boundary itself is newer than anything pending.
            if (load) begin
                display_q <= bcd_in;
            end else if (pending_valid_q) begin
                display_q <= pending_q;
            end
            pending_valid_q <= 1'b0;
        end else if (load) begin
            pending_q       <= bcd_in;
            pending_valid_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Digit selection and optional leading-zero blanking
    // ------------------------------------------------------------------
    digit_t                  disp_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   shown;
    digit_t                  cur_digit;
    logic                    cur_shown;
    seg_t                    dec_seg;

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            disp_digit[i] = display_q[4*i +: 4];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the top digit down; a digit is shown once any digit at or
    // above it is non-zero. Digit 0 is forced on so zero reads as "0".
    always_comb begin
        logic seen;
        seen  = 1'b0;
        shown = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (disp_digit[i] != 4'd0) begin
                seen = 1'b1;
            end
            shown[i] = seen;
        end
        shown[0] = 1'b1;
    end
`else
    assign shown = '1;
`endif

    always_comb begin
        cur_digit = '0;
        cur_shown = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = disp_digit[i];
                cur_shown = shown[i];
            end
        end
    end

    seg7_decode u_decode (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    // ------------------------------------------------------------------
    // Registered pin drivers: one cycle behind the scan state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= SEG_BLANK;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (pre_q == '0) && (idx_q == '0);
            if (in_blank) begin
                seg <= SEG_BLANK;
                an  <= '1;
            end else begin
                seg <= cur_shown ? dec_seg : SEG_BLANK;
                an  <= ~(NUM_DIGITS'(1) << idx_q);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver (NUM_DIGITS=4, SCAN_DIV=8,
// BLANK_CYC=1). A reference model derives the expected pins from the number
// of clock edges since reset release and the value in effect for the frame.
// Honours LEADING_ZERO_BLANK_EN when defined for the build.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int BC = 1;
    localparam int F  = N * SD;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    seg7_scan_driver #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD),
        .BLANK_CYC  (BC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .bcd_in      (bcd_in),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          k;       // rising edges since reset release
    logic [15:0] m_disp;  // value shown in the current frame
    logic [15:0] m_pend;  // newest value loaded since the last boundary
    bit          m_pv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, k);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] ref_digit_seg(input logic [15:0] v, input int i);
        logic [3:0] d;
        d = v[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        // Blank when this digit and everything above it are zero.
        if (i > 0 && (v >> (4*i)) == 16'h0) return 7'b1111111;
`endif
        return ref_seg(d);
    endfunction

    // One clock: drive inputs, take the edge, update the model, compare pins.
    task automatic step(input bit ld, input logic [15:0] val);
        logic [15:0] disp_s;
        int          s;
        int          pre_s;
        int          idx_s;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_fs;
        load   = ld;
        bcd_in = val;
        @(posedge clk);
        s      = k;        // pins after this edge reflect the state after s edges
        disp_s = m_disp;
        k++;
        if (k % F == 0) begin
            if (ld)        m_disp = val;
            else if (m_pv) m_disp = m_pend;
            m_pv = 1'b0;
        end else if (ld) begin
            m_pend = val;
            m_pv   = 1'b1;
        end
        pre_s = s % SD;
        idx_s = (s / SD) % N;
        if (pre_s < BC) begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
        end else begin
            e_an  = ~(4'b0001 << idx_s);
            e_seg = ref_digit_seg(disp_s, idx_s);
        end
        e_fs = (s % F == 0);
        #1;
        load = 1'b0;
        check("an", an, e_an);
        check("seg", seg, e_seg);
        check("frame_start", frame_start, e_fs);
    endtask

    // Advance until the pins reflect scan state s.
    task automatic goto(input int s);
        while (k < s + 1) step(1'b0, 16'h0);
    endtask

    task automatic model_reset();
        k      = 0;
        m_disp = '0;
        m_pend = '0;
        m_pv   = 1'b0;
    endtask

    initial begin
        int target;
        model_reset();

        // Reset state while held and right after release.
        #12;
        check("rst_hold_an", an, 4'hF);
        check("rst_hold_seg", seg, 7'h7F);
        check("rst_hold_fs", frame_start, 1'b0);
        #11;
        rst_n = 1'b1;
        check("rst_rel_an", an, 4'hF);
        check("rst_rel_seg", seg, 7'h7F);

        // Two idle frames: zeros scanned on every digit.
        goto(1);
        check("idle_d0_an", an, 4'b1110);
        check("idle_d0_seg", seg, 7'b1000000);
        goto(2 * F - 1);

        // Mid-frame load of 1234: held until the next boundary (edge 96).
        goto(73);
        step(1'b1, 16'h1234);
        goto(89);
        check("pre_1234_d3", seg, 7'b1000000);
        goto(97);
        check("d0_1234_an", an, 4'b1110);
        check("d0_1234_seg", seg, 7'b0011001);
        goto(121);
        check("d3_1234_an", an, 4'b0111);
        check("d3_1234_seg", seg, 7'b1111001);

        // Two loads in one frame: only the last one reaches the display.
        goto(129);
        step(1'b1, 16'h0001);
        step(1'b0, 16'h0);
        step(1'b0, 16'h0);
        step(1'b0, 16'h0);
        step(1'b1, 16'h0099);
        goto(153);
        check("old_frame_d3", seg, 7'b1111001);
        goto(161);
        check("d0_0099", seg, 7'b0010000);
        goto(169);
        check("d1_0099", seg, 7'b0010000);

        // Load on the boundary cycle goes straight to the display.
        goto(190);
        step(1'b1, 16'h5678);
        goto(193);
        check("d0_5678", seg, 7'b0000000);
        goto(201);
        check("d1_5678", seg, 7'b1111000);
        goto(209);
        check("d2_5678", seg, 7'b0000010);
        goto(217);
        check("d3_5678", seg, 7'b0010010);

        // Codes 10-15 render blank.
        goto(229);
        step(1'b1, 16'hFA0B);
        goto(257);
        check("d0_B_blank", seg, 7'b1111111);
        goto(265);
        check("d1_0_an", an, 4'b1101);
        check("d1_0_seg", seg, 7'b1000000);
        goto(273);
        check("d2_A_blank", seg, 7'b1111111);
        goto(281);
        check("d3_F_blank", seg, 7'b1111111);

        // Leading zeros: 0070.
        step(1'b1, 16'h0070);
        goto(289);
        check("d0_0070", seg, 7'b1000000);
        goto(297);
        check("d1_0070", seg, 7'b1111000);
`ifdef LEADING_ZERO_BLANK_EN
        goto(305);
        check("d2_0070", seg, 7'b1111111);
        goto(313);
        check("d3_0070", seg, 7'b1111111);
`else
        goto(305);
        check("d2_0070", seg, 7'b1000000);
        goto(313);
        check("d3_0070", seg, 7'b1000000);
`endif

        // Randomised loads, including some forced onto the boundary cycle.
        for (int n = 0; n < 800; n++) begin
            bit          ld;
            logic [15:0] v;
            v  = 16'($urandom);
            ld = ($urandom_range(0, 7) == 0);
            if (((k + 1) % F == 0) && ($urandom_range(0, 1) == 1)) ld = 1'b1;
            step(ld, v);
        end

        // Asynchronous reset in the middle of digit 2's drive phase.
        target = ((k / F) + 1) * F + 2 * SD + 4;
        goto(target);
        check("pre_rst_an", an, 4'b1011);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_an", an, 4'hF);
        check("async_rst_seg", seg, 7'h7F);
        check("async_rst_fs", frame_start, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_held_an", an, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        goto(1);
        check("restart_d0_an", an, 4'b1110);
        check("restart_d0_seg", seg, 7'b1000000);
        goto(2 * F + 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
